uart_tx_fifo: RTL and testbench

- Buffered 8N1 UART transmitter: the transmit counterpart to the platform's UART receive path.
- Accepts bytes from the core-side peripheral logic via a valid/ready handshake into a small FIFO.
- Serialises each byte onto UART_TX, LSB first, with one start bit and one stop bit.
- Instantiated inside the FPGA platform next to the receiver; shares its CLKS_PER_BIT timing so simulation can run at 5 clocks per bit.

---
 rtl/uart_tx_fifo.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter.
// Bytes are taken over a valid/ready handshake into a small FIFO, then
// shifted out LSB first, framed by one start bit and one stop bit.
// A byte waiting in the FIFO at the end of a stop bit is loaded straight
// into the shifter, so consecutive frames leave no idle gap on the line.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tx_valid,
    input  logic [7:0]                    tx_data,
    output logic                          tx_ready,
    output logic                          UART_TX,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FULL      = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            bit_done;
    logic [2:0]      bit_next;

    // Ready is decoded from registered occupancy only, never from this cycle's pop.
    assign tx_ready   = (count_q != FULL);
    assign push       = tx_valid && tx_ready;
    assign bit_done   = (baud_q == BAUD_LAST);
    assign bit_next   = bit_idx_q + 3'd1;

    assign UART_TX    = tx_q;
    assign tx_busy    = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;

    // Frame sequencer: next state, next line level and FIFO pop request.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                baud_d    = '0;
                bit_idx_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_next;
                        tx_d      = shift_q[bit_next];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    if (count_q != '0) begin
                        // Chain straight into the next start bit.
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // FIFO pointer and occupancy update; push and pop may share an edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    // State registers; reset drops any partial frame and flushes the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 5 clocks per bit, FIFO depth 4.
// A serial receiver process decodes the line into a byte queue.
module tb_uart_tx_fifo;

    localparam int CPB   = 5;
    localparam int DEPTH = 4;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready;
    logic       UART_TX;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic       mon_en  = 1'b0;
    logic [7:0] rx_q[$];
    int         rx_ferr = 0;

    logic [7:0] bytes3 [6];
    int         maxc;
    bit         saw_full;
    int         g;
    bit         ok;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .UART_TX    (UART_TX),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after the start edge; checks every cycle of one frame.
    task automatic check_frame(input logic [7:0] b, input bit last);
        for (int c = 0; c < 10 * CPB; c++) begin
            int   bi;
            logic e;
            bi = c / CPB;
            if (bi == 0)      e = 1'b0;
            else if (bi == 9) e = 1'b1;
            else              e = b[bi - 1];
            check($sformatf("frame%02h_c%0d", b, c), UART_TX, e);
            if (c == 10 * CPB - 1) check("busy_last_cycle", tx_busy, 1);
            tick();
        end
        check("busy_after_frame", tx_busy, last ? 0 : 1);
    endtask

    // Serial receiver: samples each bit at its centre.
    initial begin
        logic       prev;
        logic [7:0] d;
        logic       sb, pb;
        prev = 1'b1;
        forever begin
            tick();
            if (mon_en && prev && !UART_TX) begin
                repeat (2) tick();
                sb = UART_TX;
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) tick();
                    d[j] = UART_TX;
                end
                repeat (CPB) tick();
                pb = UART_TX;
                rx_q.push_back(d);
                if (sb !== 1'b0 || pb !== 1'b1) rx_ferr++;
                prev = UART_TX;
            end else begin
                prev = UART_TX;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bytes3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_line", UART_TX, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", tx_ready, 1);
        reset_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Single byte 0x55: latency and full frame shape
        tx_valid = 1'b1; tx_data = 8'h55;
        tick();
        tx_valid = 1'b0;
        check("t1_count_after_accept", fifo_count, 1);
        check("t1_line_still_idle", UART_TX, 1);
        check("t1_busy_queued", tx_busy, 1);
        tick();
        check_frame(8'h55, 1'b1);

        // 0x00 then 0xFF on consecutive cycles: contiguous frames
        repeat (3) tick();
        tx_valid = 1'b1; tx_data = 8'h00;
        tick();
        tx_data = 8'hFF;
        tick();
        tx_valid = 1'b0;
        check("t2_push_pop_same_edge", fifo_count, 1);
        check_frame(8'h00, 1'b0);
        check_frame(8'hFF, 1'b1);

        // Six bytes into a depth-4 FIFO, sixth held off until a pop
        repeat (3) tick();
        rx_q.delete();
        rx_ferr  = 0;
        maxc     = 0;
        saw_full = 1'b0;
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = bytes3[i];
            if (!tx_ready) begin
                saw_full = 1'b1;
                check("t3_count_full", fifo_count, 4);
                g = 0;
                while (!tx_ready && g < 200) begin
                    tick();
                    if (fifo_count > maxc) maxc = fifo_count;
                    g++;
                end
                check("t3_ready_timeout", (g < 200), 1);
                if (i == 5) begin
                    check("t3_count_after_pop", fifo_count, 3);
                    check("t3_pop_restarts_frame", UART_TX, 0);
                end
            end
            tick();
            if (fifo_count > maxc) maxc = fifo_count;
        end
        tx_valid = 1'b0;
        check("t3_count_refill", fifo_count, 4);
        check("t3_saw_full", saw_full, 1);
        check("t3_max_count", maxc, 4);
        g = 0;
        while (rx_q.size() < 6 && g < 600) begin
            tick();
            g++;
        end
        check("t3_rx_count", rx_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size()) check($sformatf("t3_rx_byte%0d", i), rx_q[i], bytes3[i]);
        end
        check("t3_no_frame_err", rx_ferr, 0);
        g = 0;
        while (tx_busy && g < 100) begin
            tick();
            g++;
        end
        repeat (20) tick();
        check("t3_no_extra_bytes", rx_q.size(), 6);

        // Reset in the middle of 0xA5 with two bytes queued
        tx_valid = 1'b1; tx_data = 8'hA5;
        tick();
        tx_data = 8'h01;
        tick();
        tx_data = 8'h02;
        tick();
        tx_valid = 1'b0;
        check("t5_queued", fifo_count, 2);
        repeat (12) tick();
        check("t5_pre_reset_line", UART_TX, 0);
        reset_n = 1'b0;
        #1;
        check("t5_rst_line", UART_TX, 1);
        check("t5_rst_count", fifo_count, 0);
        check("t5_rst_busy", tx_busy, 0);
        check("t5_rst_ready", tx_ready, 1);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (UART_TX !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
        end
        check("t5_quiet_after_release", ok, 1);
        check("t5_count_after_release", fifo_count, 0);

        // Loopback into the receiver: 0x3C then 0xC3
        rx_q.delete();
        rx_ferr  = 0;
        tx_valid = 1'b1; tx_data = 8'h3C;
        tick();
        tx_data = 8'hC3;
        tick();
        tx_valid = 1'b0;
        g = 0;
        while (rx_q.size() < 2 && g < 300) begin
            tick();
            g++;
        end
        check("lb_rx_count", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            check("lb_byte0", rx_q[0], 8'h3C);
            check("lb_byte1", rx_q[1], 8'hC3);
        end
        check("lb_no_frame_err", rx_ferr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
